// File: rtl/gpu_rect_pkg.sv
// Shared types and constants for the rectangle-fill rasterizer.
// Clipping to the screen extent is enabled by defining GPU_RECT_CLIP_EN.
package gpu_rect_pkg;

    localparam int CHANNEL_BITS  = 8;
    localparam int WIDTH_BITS    = 10;
    localparam int HEIGHT_BITS   = 9;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    localparam logic [WIDTH_BITS-1:0]  X_LIMIT = WIDTH_BITS'(SCREEN_WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LIMIT = HEIGHT_BITS'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } rectStateType;

    localparam logic RECT_OP_FILL  = 1'b0;
    localparam logic RECT_OP_FLUSH = 1'b1;

    typedef struct packed {
        logic                      op;
        logic [WIDTH_BITS-1:0]     x0;
        logic [HEIGHT_BITS-1:0]    y0;
        logic [WIDTH_BITS-1:0]     x1;
        logic [HEIGHT_BITS-1:0]    y1;
        logic [3*CHANNEL_BITS-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/gpu_rect_normalize.sv
// Corner sort, optional screen clip (GPU_RECT_CLIP_EN) and empty flag.
// Purely combinational; evaluated on the command inputs at accept.
module gpu_rect_normalize
    import gpu_rect_pkg::*;
(
    input  logic [WIDTH_BITS-1:0]  x0_i,
    input  logic [WIDTH_BITS-1:0]  x1_i,
    input  logic [HEIGHT_BITS-1:0] y0_i,
    input  logic [HEIGHT_BITS-1:0] y1_i,
    output logic [WIDTH_BITS-1:0]  xmin_o,
    output logic [WIDTH_BITS-1:0]  xmax_o,
    output logic [HEIGHT_BITS-1:0] ymin_o,
    output logic [HEIGHT_BITS-1:0] ymax_o,
    output logic                   empty_o
);

    logic [WIDTH_BITS-1:0]  xhi;
    logic [HEIGHT_BITS-1:0] yhi;

    always_comb begin
        xmin_o = (x0_i < x1_i) ? x0_i : x1_i;
        xhi    = (x0_i < x1_i) ? x1_i : x0_i;
        ymin_o = (y0_i < y1_i) ? y0_i : y1_i;
        yhi    = (y0_i < y1_i) ? y1_i : y0_i;
`ifdef GPU_RECT_CLIP_EN
        xmax_o  = (xhi > X_LIMIT) ? X_LIMIT : xhi;
        ymax_o  = (yhi > Y_LIMIT) ? Y_LIMIT : yhi;
        // A start corner past the edge leaves nothing visible
        empty_o = (xmin_o > X_LIMIT) || (ymin_o > Y_LIMIT);
`else
        xmax_o  = xhi;
        ymax_o  = yhi;
        empty_o = 1'b0;
`endif
    end

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill rasterizer: one pixel per clock in row-major order,
// plus a one-cycle flush pulse. Optional clipping via GPU_RECT_CLIP_EN.
module gpu_rect_fill
    import gpu_rect_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_op_i,
    input  logic [WIDTH_BITS-1:0]   cmd_x0_i,
    input  logic [WIDTH_BITS-1:0]   cmd_x1_i,
    input  logic [HEIGHT_BITS-1:0]  cmd_y0_i,
    input  logic [HEIGHT_BITS-1:0]  cmd_y1_i,
    input  logic [3*CHANNEL_BITS-1:0] cmd_color_i,
    output logic                    data_ready_o,
    output logic [CHANNEL_BITS-1:0] rdata_o,
    output logic [CHANNEL_BITS-1:0] gdata_o,
    output logic [CHANNEL_BITS-1:0] bdata_o,
    output logic [WIDTH_BITS-1:0]   adddatax_o,
    output logic [HEIGHT_BITS-1:0]  adddatay_o,
    output logic                    flush_o,
    output logic                    busy_o
);

    rect_cmd_t cmd;
    rectStateType state_q, state_d;

    logic [WIDTH_BITS-1:0]  x_q, x_d;
    logic [WIDTH_BITS-1:0]  xmin_q, xmin_d;
    logic [WIDTH_BITS-1:0]  xmax_q, xmax_d;
    logic [HEIGHT_BITS-1:0] y_q, y_d;
    logic [HEIGHT_BITS-1:0] ymax_q, ymax_d;
    logic [3*CHANNEL_BITS-1:0] color_q, color_d;
    logic dr_q, dr_d;
    logic flush_q, flush_d;
    logic busy_q, busy_d;

    logic [WIDTH_BITS-1:0]  n_xmin, n_xmax;
    logic [HEIGHT_BITS-1:0] n_ymin, n_ymax;
    logic n_empty;
    logic accept;

    assign cmd = '{op: cmd_op_i, x0: cmd_x0_i, y0: cmd_y0_i,
                   x1: cmd_x1_i, y1: cmd_y1_i, color: cmd_color_i};

    gpu_rect_normalize u_norm (
        .x0_i    (cmd.x0),
        .x1_i    (cmd.x1),
        .y0_i    (cmd.y0),
        .y1_i    (cmd.y1),
        .xmin_o  (n_xmin),
        .xmax_o  (n_xmax),
        .ymin_o  (n_ymin),
        .ymax_o  (n_ymax),
        .empty_o (n_empty)
    );

    assign cmd_ready_o = (state_q == IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        color_d = color_q;
        dr_d    = 1'b0;
        flush_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd.op == RECT_OP_FLUSH) begin
                        state_d = FLUSH;
                        flush_d = 1'b1;
                    end else if (!n_empty) begin
                        // Counters double as the registered pixel outputs
                        state_d = FILL;
                        dr_d    = 1'b1;
                        x_d     = n_xmin;
                        y_d     = n_ymin;
                        xmin_d  = n_xmin;
                        xmax_d  = n_xmax;
                        ymax_d  = n_ymax;
                        color_d = cmd.color;
                    end
                end
            end
            FILL: begin
                if (x_q == xmax_q) begin
                    if (y_q == ymax_q) begin
                        state_d = IDLE;
                    end else begin
                        dr_d = 1'b1;
                        x_d  = xmin_q;
                        y_d  = y_q + 1'b1;
                    end
                end else begin
                    dr_d = 1'b1;
                    x_d  = x_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            color_q <= '0;
            dr_q    <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            color_q <= color_d;
            dr_q    <= dr_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
        end
    end

    assign data_ready_o = dr_q;
    assign flush_o      = flush_q;
    assign busy_o       = busy_q;
    assign adddatax_o   = x_q;
    assign adddatay_o   = y_q;
    assign rdata_o      = color_q[3*CHANNEL_BITS-1:2*CHANNEL_BITS];
    assign gdata_o      = color_q[2*CHANNEL_BITS-1:CHANNEL_BITS];
    assign bdata_o      = color_q[CHANNEL_BITS-1:0];

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Scoreboard bench for gpu_rect_fill: directed cases plus a random
// command stream against a row-major reference model.
module tb_gpu_rect_fill;
    import gpu_rect_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    logic cmd_valid_i, cmd_ready_o, cmd_op_i;
    logic [WIDTH_BITS-1:0]  cmd_x0_i, cmd_x1_i;
    logic [HEIGHT_BITS-1:0] cmd_y0_i, cmd_y1_i;
    logic [3*CHANNEL_BITS-1:0] cmd_color_i;
    logic data_ready_o, flush_o, busy_o;
    logic [CHANNEL_BITS-1:0] rdata_o, gdata_o, bdata_o;
    logic [WIDTH_BITS-1:0]  adddatax_o;
    logic [HEIGHT_BITS-1:0] adddatay_o;

    gpu_rect_fill dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_x0_i     (cmd_x0_i),
        .cmd_x1_i     (cmd_x1_i),
        .cmd_y0_i     (cmd_y0_i),
        .cmd_y1_i     (cmd_y1_i),
        .cmd_color_i  (cmd_color_i),
        .data_ready_o (data_ready_o),
        .rdata_o      (rdata_o),
        .gdata_o      (gdata_o),
        .bdata_o      (bdata_o),
        .adddatax_o   (adddatax_o),
        .adddatay_o   (adddatay_o),
        .flush_o      (flush_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fl;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t expq[$];
    int passed = 0;
    int total = 0;
    int flush_cmds = 0;
    int flush_seen = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pix(input int x, input int y, input int c);
        logic [WIDTH_BITS-1:0] xs;
        logic [HEIGHT_BITS-1:0] ys;
        logic [23:0] cs;
        xs = x[WIDTH_BITS-1:0];
        ys = y[HEIGHT_BITS-1:0];
        cs = c[23:0];
        return 64'({2'b10, xs, ys, cs});
    endfunction

    function automatic logic [63:0] actual();
        return 64'({data_ready_o, flush_o, adddatax_o, adddatay_o,
                    rdata_o, gdata_o, bdata_o});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_rst && (data_ready_o || flush_o)) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", actual(), 64'd0);
                end else begin
                    e = expq.pop_front();
                    if (e.fl) begin
                        flush_seen++;
                        check("flush_event", 64'({flush_o, data_ready_o}),
                              64'(2'b10));
                    end else begin
                        check("pixel", actual(), pix(e.x, e.y, e.c));
                    end
                end
            end
        end
    end

    // Reference model: returns pixel count and pushes the expected stream
    function automatic int model(input bit op, input int x0, input int y0,
                                 input int x1, input int y1, input int c);
        int xl, xh, yl, yh;
        if (op) begin
            expq.push_back('{fl: 1'b1, x: 0, y: 0, c: 0});
            return 0;
        end
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
`ifdef GPU_RECT_CLIP_EN
        if (xh > SCREEN_WIDTH - 1) xh = SCREEN_WIDTH - 1;
        if (yh > SCREEN_HEIGHT - 1) yh = SCREEN_HEIGHT - 1;
        if (xl >= SCREEN_WIDTH || yl >= SCREEN_HEIGHT) return 0;
`endif
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                expq.push_back('{fl: 1'b0, x: x, y: y, c: c});
        return (xh - xl + 1) * (yh - yl + 1);
    endfunction

    task automatic drive_accept(input bit op, input int x0, input int y0,
                                input int x1, input int y1, input int c);
        int g;
        cmd_op_i    = op;
        cmd_x0_i    = x0[WIDTH_BITS-1:0];
        cmd_y0_i    = y0[HEIGHT_BITS-1:0];
        cmd_x1_i    = x1[WIDTH_BITS-1:0];
        cmd_y1_i    = y1[HEIGHT_BITS-1:0];
        cmd_color_i = c[23:0];
        cmd_valid_i = 1'b1;
        g = 0;
        while (!cmd_ready_o && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with ready high
    task automatic run_cmd(input string tag, input bit op, input int x0,
                           input int y0, input int x1, input int y1,
                           input int c);
        int p, npix, nbusy, fpos, lat;
        p = model(op, x0, y0, x1, y1, c);
        if (op) flush_cmds++;
        drive_accept(op, x0, y0, x1, y1, c);
        npix = 0; nbusy = 0; fpos = 0; lat = 0;
        for (int k = 1; k <= 2000; k++) begin
            cmd_op_i    = 1'($urandom);
            cmd_x0_i    = WIDTH_BITS'($urandom);
            cmd_y1_i    = HEIGHT_BITS'($urandom);
            cmd_color_i = 24'($urandom);
            @(negedge clk);
            if (data_ready_o) npix++;
            if (busy_o) nbusy++;
            if (flush_o && fpos == 0) fpos = k;
            if (cmd_ready_o) begin
                lat = k;
                break;
            end
        end
        if (op) begin
            check({tag, "_flush_cycle"}, 64'(fpos), 64'd1);
            check({tag, "_ready_lat"}, 64'(lat), 64'd2);
            check({tag, "_busy_cycles"}, 64'(nbusy), 64'd1);
        end else begin
            check({tag, "_pixels"}, 64'(npix), 64'(p));
            check({tag, "_ready_lat"}, 64'(lat), 64'(p + 1));
            check({tag, "_busy_cycles"}, 64'(nbusy), 64'(p));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x0, x1, y0, y1, xr, yr, cnt;
        n_rst = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i = 1'b0;
        cmd_x0_i = '0; cmd_x1_i = '0;
        cmd_y0_i = '0; cmd_y1_i = '0;
        cmd_color_i = '0;
        #12;
        check("reset_ctrl", 64'({cmd_ready_o, busy_o, data_ready_o, flush_o}),
              64'(4'b1000));
        check("reset_data", actual(), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        run_cmd("fill_2x2", RECT_OP_FILL, 4, 6, 3, 5, 32'hFF0000);
        run_cmd("fill_1px", RECT_OP_FILL, 7, 9, 7, 9, 32'h00AB12);
        run_cmd("fill_1x3", RECT_OP_FILL, 2, 10, 2, 12, 32'h123456);
        run_cmd("flush_b2b", RECT_OP_FLUSH, 0, 0, 0, 0, 0);

`ifdef GPU_RECT_CLIP_EN
        run_cmd("clip_edge", RECT_OP_FILL, SCREEN_WIDTH - 2, 0,
                SCREEN_WIDTH + 5, 0, 32'h0F0F0F);
        run_cmd("clip_empty", RECT_OP_FILL, SCREEN_WIDTH, 0,
                SCREEN_WIDTH, 0, 32'hFFFFFF);
`endif

        // Reset aborts a 10x10 fill at its 37th pixel
        for (int i = 0; i < 37; i++)
            expq.push_back('{fl: 1'b0, x: i % 10, y: 20 + i / 10, c: 32'h55AA33});
        drive_accept(RECT_OP_FILL, 9, 29, 0, 20, 32'h55AA33);
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 37; k++) begin
            @(negedge clk);
            if (data_ready_o) cnt++;
        end
        check("rst_pixels_before", 64'(cnt), 64'd37);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_abort_ctrl",
              64'({cmd_ready_o, busy_o, data_ready_o, flush_o}), 64'(4'b1000));
        check("rst_abort_data", actual(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_queue_empty", 64'(expq.size()), 64'd0);
        run_cmd("post_rst_2x1", RECT_OP_FILL, 20, 3, 21, 3, 32'hC0FFEE);

`ifdef GPU_RECT_CLIP_EN
        xr = (1 << WIDTH_BITS) - 1;
        yr = (1 << HEIGHT_BITS) - 1;
`else
        xr = SCREEN_WIDTH - 1;
        yr = SCREEN_HEIGHT - 1;
`endif
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                run_cmd("rand_flush", RECT_OP_FLUSH, 0, 0, 0, 0, 0);
            end else begin
                x0 = $urandom_range(0, xr);
                y0 = $urandom_range(0, yr);
                x1 = x0 + $urandom_range(0, 10) - 5;
                y1 = y0 + $urandom_range(0, 6) - 3;
                if (x1 < 0) x1 = 0;
                if (x1 > xr) x1 = xr;
                if (y1 < 0) y1 = 0;
                if (y1 > yr) y1 = yr;
                run_cmd("rand_fill", RECT_OP_FILL, x0, y0, x1, y1,
                        int'($urandom_range(0, 24'hFFFFFF)));
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(expq.size()), 64'd0);
        check("flush_count", 64'(flush_seen), 64'(flush_cmds));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
